b1_corr_bank: RTL and testbench

Parametrised multi-tap integrate-and-dump correlator bank for the B1 tracking channel. It sits between the carrier/code wipe-off stage and the PLL/DLL discriminators. Each of `NTAP` local BOC replicas correlates the complex baseband input over a configurable number of PRN periods. Accumulators saturate, and each dump is delivered through a valid/ready handshake with overrun and saturation reporting.

---
 rtl/b1_corr_bank.sv | 184 ++++++++++++++++++
 tb/tb_b1_corr_bank.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/b1_corr_bank.sv
// Multi-tap integrate-and-dump correlator bank for the B1 tracking channel.
// Saturating accumulators with a valid/ready dump port and overrun reporting.
module b1_corr_bank #(
    parameter int NTAP  = 3,
    parameter int IW    = 16,
    parameter int ACC_W = 30,
    parameter int OW    = 24
) (
    input  logic                   rx_clk,
    input  logic                   rx_rst,
    input  logic [IW-1:0]          rx_src_real,
    input  logic [IW-1:0]          rx_src_imag,
    input  logic [NTAP-1:0]        rx_loc_boc,
    input  logic                   rx_prn_sop,
    input  logic [7:0]             cfg_int_len,
    output logic                   tx_dump_valid,
    input  logic                   tx_dump_ready,
    output logic [NTAP*OW-1:0]     tx_dump_real,
    output logic [NTAP*OW-1:0]     tx_dump_imag,
    output logic                   tx_dump_sat,
    output logic [31:0]            tx_dump_cnt,
    output logic                   tx_overrun
);

    typedef enum logic [0:0] {IDLE, ACC} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Negating the most negative code clamps to the most positive one.
    function automatic logic [IW-1:0] neg_sat(input logic [IW-1:0] x);
        if (x == {1'b1, {(IW-1){1'b0}}})
            return {1'b0, {(IW-1){1'b1}}};
        return -x;
    endfunction

    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        logic [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (s[ACC_W] != s[ACC_W-1])
            return {1'b1, s[ACC_W] ? ACC_MIN : ACC_MAX};
        return {1'b0, s[ACC_W-1:0]};
    endfunction

    state_t             state_q, state_d;
    logic [7:0]         per_q, per_d;
    logic [7:0]         len_q, len_d;
    logic               sat_q, sat_d;
    logic [ACC_W-1:0]   acc_re_q [NTAP];
    logic [ACC_W-1:0]   acc_re_d [NTAP];
    logic [ACC_W-1:0]   acc_im_q [NTAP];
    logic [ACC_W-1:0]   acc_im_d [NTAP];
    logic [NTAP*OW-1:0] dre_q, dre_d;
    logic [NTAP*OW-1:0] dim_q, dim_d;
    logic               dsat_q, dsat_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;

    logic [ACC_W-1:0]   ext_re [NTAP];
    logic [ACC_W-1:0]   ext_im [NTAP];
    logic [ACC_W-1:0]   sum_re [NTAP];
    logic [ACC_W-1:0]   sum_im [NTAP];
    logic [NTAP-1:0]    clip_re, clip_im;
    logic [7:0]         eff_len;
    logic               dump;

    always_comb begin
        for (int k = 0; k < NTAP; k++) begin
            logic [IW-1:0] vr, vi;
            vr = rx_loc_boc[k] ? neg_sat(rx_src_real) : rx_src_real;
            vi = rx_loc_boc[k] ? neg_sat(rx_src_imag) : rx_src_imag;
            ext_re[k] = {{(ACC_W-IW){vr[IW-1]}}, vr};
            ext_im[k] = {{(ACC_W-IW){vi[IW-1]}}, vi};
            {clip_re[k], sum_re[k]} = sat_add(acc_re_q[k], ext_re[k]);
            {clip_im[k], sum_im[k]} = sat_add(acc_im_q[k], ext_im[k]);
        end
    end

    assign eff_len = (cfg_int_len == 8'd0) ? 8'd1 : cfg_int_len;
    assign dump    = (state_q == ACC) && rx_prn_sop && (per_q == len_q);

    always_comb begin
        state_d  = state_q;
        per_d    = per_q;
        len_d    = len_q;
        sat_d    = sat_q;
        acc_re_d = acc_re_q;
        acc_im_d = acc_im_q;
        dre_d    = dre_q;
        dim_d    = dim_q;
        dsat_d   = dsat_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        ovr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                for (int k = 0; k < NTAP; k++) begin
                    acc_re_d[k] = '0;
                    acc_im_d[k] = '0;
                end
                if (rx_prn_sop) begin
                    acc_re_d = ext_re;
                    acc_im_d = ext_im;
                    per_d    = 8'd1;
                    len_d    = eff_len;
                    sat_d    = 1'b0;
                    state_d  = ACC;
                end
            end
            ACC: begin
                if (dump) begin
                    for (int k = 0; k < NTAP; k++) begin
                        dre_d[k*OW +: OW] = acc_re_q[k][ACC_W-1 -: OW];
                        dim_d[k*OW +: OW] = acc_im_q[k][ACC_W-1 -: OW];
                    end
                    dsat_d   = sat_q;
                    acc_re_d = ext_re;
                    acc_im_d = ext_im;
                    per_d    = 8'd1;
                    len_d    = eff_len;
                    sat_d    = 1'b0;
                    if (cnt_q != 32'hFFFF_FFFF)
                        cnt_d = cnt_q + 32'd1;
                end else begin
                    acc_re_d = sum_re;
                    acc_im_d = sum_im;
                    sat_d    = sat_q | (|clip_re) | (|clip_im);
                    if (rx_prn_sop)
                        per_d = per_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A same-cycle accept is superseded by the new dump.
        if (dump) begin
            valid_d = 1'b1;
            ovr_d   = valid_q && !tx_dump_ready;
        end else if (valid_q && tx_dump_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            state_q <= IDLE;
            per_q   <= '0;
            len_q   <= 8'd1;
            sat_q   <= 1'b0;
            for (int k = 0; k < NTAP; k++) begin
                acc_re_q[k] <= '0;
                acc_im_q[k] <= '0;
            end
            dre_q   <= '0;
            dim_q   <= '0;
            dsat_q  <= 1'b0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            len_q    <= len_d;
            sat_q    <= sat_d;
            acc_re_q <= acc_re_d;
            acc_im_q <= acc_im_d;
            dre_q    <= dre_d;
            dim_q    <= dim_d;
            dsat_q   <= dsat_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign tx_dump_valid = valid_q;
    assign tx_dump_real  = dre_q;
    assign tx_dump_imag  = dim_q;
    assign tx_dump_sat   = dsat_q;
    assign tx_dump_cnt   = cnt_q;
    assign tx_overrun    = ovr_q;

endmodule

// File: tb/tb_b1_corr_bank.sv
// Scoreboard bench for b1_corr_bank: directed periods push expected dumps,
// a negedge monitor pops and compares each newly presented dump.
module tb_b1_corr_bank;

    logic        rx_clk = 1'b0;
    logic        rx_rst;
    logic [15:0] rx_src_real, rx_src_imag;
    logic [2:0]  rx_loc_boc;
    logic        rx_prn_sop;
    logic [7:0]  cfg_int_len;
    logic        tx_dump_valid, tx_dump_ready;
    logic [71:0] tx_dump_real, tx_dump_imag;
    logic        tx_dump_sat;
    logic [31:0] tx_dump_cnt;
    logic        tx_overrun;

    b1_corr_bank dut (
        .rx_clk(rx_clk), .rx_rst(rx_rst),
        .rx_src_real(rx_src_real), .rx_src_imag(rx_src_imag),
        .rx_loc_boc(rx_loc_boc), .rx_prn_sop(rx_prn_sop),
        .cfg_int_len(cfg_int_len),
        .tx_dump_valid(tx_dump_valid), .tx_dump_ready(tx_dump_ready),
        .tx_dump_real(tx_dump_real), .tx_dump_imag(tx_dump_imag),
        .tx_dump_sat(tx_dump_sat), .tx_dump_cnt(tx_dump_cnt),
        .tx_overrun(tx_overrun)
    );

    always #5 rx_clk = ~rx_clk;

    typedef struct packed {
        logic [71:0] re;
        logic [71:0] im;
        logic        sat;
        logic        ov;
        logic [31:0] cnt;
        logic [31:0] cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   ov_seen = 0;
    logic [31:0] last_cnt = 32'd0;

    always @(posedge rx_clk) cyc++;

    task automatic chk(string name, longint act, longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic push(int r0, int r1, int r2, int i0, int i1, int i2,
                        bit sat, bit ov, int cnt);
        exp_t e;
        e.re  = {24'(r2), 24'(r1), 24'(r0)};
        e.im  = {24'(i2), 24'(i1), 24'(i0)};
        e.sat = sat;
        e.ov  = ov;
        e.cnt = cnt;
        e.cyc = cyc + 1;
        q.push_back(e);
    endtask

    always @(negedge rx_clk) begin
        if (tx_overrun === 1'b1) ov_seen++;
        if (tx_dump_cnt !== last_cnt && !$isunknown(tx_dump_cnt)) begin
            if (tx_dump_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_dump", tx_dump_cnt, -1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    for (int k = 0; k < 3; k++) begin
                        chk($sformatf("dump%0d_re%0d", e.cnt, k),
                            $signed(tx_dump_real[k*24 +: 24]),
                            $signed(e.re[k*24 +: 24]));
                        chk($sformatf("dump%0d_im%0d", e.cnt, k),
                            $signed(tx_dump_imag[k*24 +: 24]),
                            $signed(e.im[k*24 +: 24]));
                    end
                    chk($sformatf("dump%0d_sat", e.cnt), tx_dump_sat, e.sat);
                    chk($sformatf("dump%0d_ovr", e.cnt), tx_overrun, e.ov);
                    chk($sformatf("dump%0d_cnt", e.cnt), tx_dump_cnt, e.cnt);
                    chk($sformatf("dump%0d_cycle", e.cnt), cyc, e.cyc);
                end
            end
            last_cnt = tx_dump_cnt;
        end
    end

    task automatic step(bit sop, int re, int im, logic [2:0] boc);
        rx_prn_sop  = sop;
        rx_src_real = 16'(re);
        rx_src_imag = 16'(im);
        rx_loc_boc  = boc;
        @(posedge rx_clk);
        #1;
    endtask

    task automatic period(int n, int re, int im, logic [2:0] boc);
        step(1'b1, re, im, boc);
        repeat (n - 1) step(1'b0, re, im, boc);
    endtask

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_rst = 1'b1;
        rx_src_real = '0;
        rx_src_imag = '0;
        rx_loc_boc = '0;
        rx_prn_sop = 1'b0;
        cfg_int_len = 8'd1;
        tx_dump_ready = 1'b1;
        repeat (2) @(posedge rx_clk);
        #1;
        chk("rst_valid", tx_dump_valid, 0);
        chk("rst_ovr", tx_overrun, 0);
        chk("rst_sat", tx_dump_sat, 0);
        chk("rst_real", tx_dump_real, 0);
        chk("rst_imag", tx_dump_imag, 0);
        chk("rst_cnt", tx_dump_cnt, 0);
        rx_rst = 1'b0;
        repeat (5) step(1'b0, 999, 999, 3'b000);

        period(1000, 64, -32, 3'b000);
        push(1000, 1000, 1000, -500, -500, -500, 0, 0, 1);
        period(1000, 64, -32, 3'b010);
        push(1000, -1000, 1000, -500, 500, -500, 0, 0, 2);
        period(10, -32768, 0, 3'b010);

        push(-5120, 5119, -5120, 0, 0, 0, 0, 0, 3);
        cfg_int_len = 8'd4;
        repeat (4) period(1000, 64, -32, 3'b000);
        push(4000, 4000, 4000, -2000, -2000, -2000, 0, 0, 4);
        period(1000, 64, -32, 3'b000);
        period(500, 64, -32, 3'b000);
        cfg_int_len = 8'd2;
        repeat (500) step(1'b0, 64, -32, 3'b000);
        repeat (2) period(1000, 64, -32, 3'b000);
        push(4000, 4000, 4000, -2000, -2000, -2000, 0, 0, 5);
        period(1000, 64, -32, 3'b000);
        cfg_int_len = 8'd0;
        period(1000, 64, -32, 3'b000);
        push(2000, 2000, 2000, -1000, -1000, -1000, 0, 0, 6);
        period(1000, 64, -32, 3'b000);

        push(1000, 1000, 1000, -500, -500, -500, 0, 0, 7);
        tx_dump_ready = 1'b0;
        period(100, 64, -32, 3'b000);
        push(100, 100, 100, -50, -50, -50, 0, 1, 8);
        step(1'b1, 128, -32, 3'b000);
        chk("ovr_valid_held", tx_dump_valid, 1);
        tx_dump_ready = 1'b1;
        step(1'b0, 128, -32, 3'b000);
        tx_dump_ready = 1'b0;
        chk("ovr_valid_drop", tx_dump_valid, 0);
        repeat (98) step(1'b0, 128, -32, 3'b000);
        tx_dump_ready = 1'b1;
        push(200, 200, 200, -50, -50, -50, 0, 0, 9);
        period(50, 64, -32, 3'b000);

        push(50, 50, 50, -25, -25, -25, 0, 0, 10);
        period(20000, 32767, 0, 3'b000);
        push(8388607, 8388607, 8388607, 0, 0, 0, 1, 0, 11);
        period(100, 64, -32, 3'b000);

        push(100, 100, 100, -50, -50, -50, 0, 0, 12);
        tx_dump_ready = 1'b0;
        period(50, 64, -32, 3'b000);
        chk("mid_valid", tx_dump_valid, 1);
        rx_rst = 1'b1;
        step(1'b0, 64, -32, 3'b000);
        rx_rst = 1'b0;
        chk("mid_rst_valid", tx_dump_valid, 0);
        chk("mid_rst_cnt", tx_dump_cnt, 0);
        chk("mid_rst_real", tx_dump_real, 0);
        chk("mid_rst_imag", tx_dump_imag, 0);
        chk("mid_rst_sat", tx_dump_sat, 0);
        chk("mid_rst_ovr", tx_overrun, 0);
        repeat (30) step(1'b0, 1000, 1000, 3'b000);
        tx_dump_ready = 1'b1;
        period(100, 64, -32, 3'b000);
        push(100, 100, 100, -50, -50, -50, 0, 0, 1);
        step(1'b1, 0, 0, 3'b000);
        repeat (5) step(1'b0, 0, 0, 3'b000);

        chk("queue_drained", q.size(), 0);
        chk("overrun_total", ov_seen, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
